genevr_reg_bus_arbiter: RTL and testbench

//  Shares the single register bus (req/rd_wr_L/addr/wr_data -> ack/rd_data) between NUM_MASTERS requesters.

---
 rtl/genevr_reg_arb_pkg.sv | 19 +
 rtl/genevr_rr_arbiter.sv | 39 +++
 rtl/genevr_reg_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_genevr_reg_bus_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genevr_reg_arb_pkg.sv
// Shared types and helpers for the genevr register bus arbiter.
package genevr_reg_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Read data returned to a master whose transaction timed out.
  localparam logic [31:0] REG_ERR_DATA = 32'hdead_beef;

  // Width of a binary index able to hold 0..n-1 (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/genevr_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after rr_ptr,
// searching circularly. Produces a one-hot grant, its binary index and any_req.
module genevr_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] grant_oh,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   any_req
);

  logic found;
  int   cand;

  // Walk the circular order starting at rr_ptr and take the first requester.
  always_comb begin
    // NOTE: every variable gets a default before the search so no path leaves
    // a value held over from a previous evaluation (that would infer a latch).
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && req[i] && (cand == i)) begin
          found       = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/genevr_reg_bus_arbiter.sv
// Shares the single genevr register bus between NUM_MASTERS requesters.
// Round-robin grant, one outstanding transaction, and the held slave ack is
// drained before the bus is granted again.
// Optional no-ack timeout: define GENEVR_REG_ARB_TIMEOUT_EN to build the
// timeout counter; without it REQ waits indefinitely and m_err is tied low.
module genevr_reg_bus_arbiter
  import genevr_reg_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 23,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_MASTERS-1:0]                m_req,
  input  logic [NUM_MASTERS-1:0]                m_rd_wr_L,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_wr_data,
  output logic [NUM_MASTERS-1:0]                m_ack,
  output logic [AXI_DATA_WIDTH-1:0]             m_rd_data,
  output logic                                  m_err,
  output logic                                  reg_req_out,
  output logic                                  reg_rd_wr_L_out,
  output logic [AXI_ADDR_WIDTH-1:0]             reg_addr_out,
  output logic [AXI_DATA_WIDTH-1:0]             reg_wr_data_out,
  input  logic                                  reg_ack_in,
  input  logic [AXI_DATA_WIDTH-1:0]             reg_rd_data_in
);

  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int DW    = AXI_DATA_WIDTH;
  localparam int IDX_W = idx_width(NUM_MASTERS);

  // Reject configurations the arbiter cannot serve at elaboration time.
  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("genevr_reg_bus_arbiter: NUM_MASTERS and TIMEOUT_CYCLES must be >= 2");
  end

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       next_ptr;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [NUM_MASTERS-1:0] ack_vec;
  logic                   sel_rw;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_wd;

`ifdef GENEVR_REG_ARB_TIMEOUT_EN
  localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;
`else
  assign m_err = 1'b0;
`endif

  genevr_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .req       (m_req),
    .rr_ptr    (rr_ptr),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  // Select the picked master's request fields (one-hot OR mux).
  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_oh[i]) begin
        sel_rw   = m_rd_wr_L[i];
        sel_addr = m_addr[i*AW +: AW];
        sel_wd   = m_wr_data[i*DW +: DW];
      end
    end
  end

  // Completion pulse pattern for the granted master and the post-grant pointer.
  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      ack_vec[i] = (grant_q == IDX_W'(i));
    end
    next_ptr = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
  end

  // Arbiter FSM: grant in IDLE, hold the bus in REQ, wait out the ack in DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_q         <= '0;
      m_ack           <= '0;
      m_rd_data       <= '0;
      reg_req_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_wr_data_out <= '0;
`ifdef GENEVR_REG_ARB_TIMEOUT_EN
      m_err           <= 1'b0;
      to_cnt          <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register updates
      // from the values present before the edge, independent of statement order.
      m_ack <= '0;
`ifdef GENEVR_REG_ARB_TIMEOUT_EN
      m_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q         <= pick_idx;
            reg_rd_wr_L_out <= sel_rw;
            reg_addr_out    <= sel_addr;
            reg_wr_data_out <= sel_wd;
            reg_req_out     <= 1'b1;
            state           <= REQ;
`ifdef GENEVR_REG_ARB_TIMEOUT_EN
            to_cnt          <= '0;
`endif
          end
        end
        REQ: begin
          if (reg_ack_in) begin
            m_rd_data   <= reg_rd_data_in;
            m_ack       <= ack_vec;
            reg_req_out <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= DRAIN;
          end
`ifdef GENEVR_REG_ARB_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            m_rd_data   <= DW'(REG_ERR_DATA);
            m_err       <= 1'b1;
            m_ack       <= ack_vec;
            reg_req_out <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= DRAIN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (!reg_ack_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_genevr_reg_bus_arbiter.sv
// Directed self-checking bench for genevr_reg_bus_arbiter (2 masters,
// 23-bit address, 32-bit data, TIMEOUT_CYCLES=16) with a registered slave model.
module tb_genevr_reg_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 23;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_rd_wr_L;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wr_data;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_rd_data;
  logic            m_err;
  logic            reg_req_out;
  logic            reg_rd_wr_L_out;
  logic [AW-1:0]   reg_addr_out;
  logic [DW-1:0]   reg_wr_data_out;
  logic            reg_ack_in;
  logic [DW-1:0]   reg_rd_data_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model controls.
  logic          slave_en;
  int            slave_hold;
  logic [DW-1:0] slave_data;
  int            hold_cnt;

  // Monitor state.
  int            ack_total  = 0;
  int            multi_hot  = 0;
  int            unstable   = 0;
  int            err_no_ack = 0;
  logic          prev_req   = 1'b0;
  logic          prev_rw    = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [DW-1:0] prev_wd    = '0;

  genevr_reg_bus_arbiter #(
    .NUM_MASTERS    (N),
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m_req           (m_req),
    .m_rd_wr_L       (m_rd_wr_L),
    .m_addr          (m_addr),
    .m_wr_data       (m_wr_data),
    .m_ack           (m_ack),
    .m_rd_data       (m_rd_data),
    .m_err           (m_err),
    .reg_req_out     (reg_req_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_wr_data_out (reg_wr_data_out),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_data_in  (reg_rd_data_in)
  );

  always #5 clk = ~clk;

  // Registered slave: acks the cycle after it sees req, holds ack while req is
  // high, then for slave_hold extra cycles after req drops.
  always @(posedge clk) begin
    if (reset) begin
      reg_ack_in     <= 1'b0;
      reg_rd_data_in <= '0;
      hold_cnt       <= 0;
    end else if (reg_req_out && slave_en) begin
      reg_ack_in     <= 1'b1;
      reg_rd_data_in <= slave_data;
      hold_cnt       <= slave_hold;
    end else if (reg_ack_in && hold_cnt != 0) begin
      hold_cnt <= hold_cnt - 1;
    end else begin
      reg_ack_in <= 1'b0;
    end
  end

  // Protocol monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_ack != '0) ack_total++;
      if ($countones(m_ack) > 1) multi_hot++;
      if (m_err && m_ack == '0) err_no_ack++;
      if (reg_req_out && prev_req &&
          (reg_addr_out != prev_addr || reg_wr_data_out != prev_wd ||
           reg_rd_wr_L_out != prev_rw)) unstable++;
    end
    prev_req  = reg_req_out;
    prev_addr = reg_addr_out;
    prev_wd   = reg_wr_data_out;
    prev_rw   = reg_rd_wr_L_out;
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Tick until any m_ack pulse or the cycle budget runs out, then check it.
  task automatic wait_ack(input string tag, input logic [N-1:0] exp_ack, input int max_cycles);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (m_ack == '0 && n < max_cycles);
    check(tag, 64'(m_ack), 64'(exp_ack));
  endtask

  task automatic set_master(input int idx, input logic rw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
    m_rd_wr_L[idx]          = rw;
    m_addr[idx*AW +: AW]    = addr;
    m_wr_data[idx*DW +: DW] = wd;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_req = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    m_req      = '0;
    m_rd_wr_L  = '0;
    m_addr     = '0;
    m_wr_data  = '0;
    slave_en   = 1'b1;
    slave_hold = 0;
    slave_data = '0;

    // ---- Reset state ----
    tick();
    tick();
    check("rst_m_ack", 64'(m_ack), 64'h0);
    check("rst_req", 64'(reg_req_out), 64'h0);
    check("rst_rw", 64'(reg_rd_wr_L_out), 64'h0);
    check("rst_addr", 64'(reg_addr_out), 64'h0);
    check("rst_wd", 64'(reg_wr_data_out), 64'h0);
    check("rst_rdata", 64'(m_rd_data), 64'h0);
    check("rst_err", 64'(m_err), 64'h0);
    reset = 1'b0;
    tick();

    // ---- 1: single read from m0, exact latency ----
    set_master(0, 1'b1, 23'h4005c1, 32'h0);
    slave_data = 32'h1234_5678;
    m_req      = 2'b01;                      // cycle 0
    tick();                                  // cycle 1
    check("t1_req_c1", 64'(reg_req_out), 64'h1);
    check("t1_addr_c1", 64'(reg_addr_out), 64'h4005c1);
    check("t1_rw_c1", 64'(reg_rd_wr_L_out), 64'h1);
    tick();                                  // cycle 2
    check("t1_noack_c2", 64'(m_ack), 64'h0);
    tick();                                  // cycle 3
    check("t1_ack_c3", 64'(m_ack), 64'h1);
    check("t1_rdata", 64'(m_rd_data), 64'h1234_5678);
    check("t1_err", 64'(m_err), 64'h0);
    check("t1_req_drop", 64'(reg_req_out), 64'h0);
    m_req = 2'b00;
    tick();                                  // cycle 4
    check("t1_ack_pulse", 64'(m_ack), 64'h0);
    tick();

    // ---- 2: simultaneous requests from rr_ptr=0 ----
    apply_reset();
    set_master(0, 1'b1, 23'h000010, 32'h0);
    set_master(1, 1'b1, 23'h100020, 32'h0);
    slave_data = 32'haaaa_0000;
    m_req      = 2'b11;                      // cycle 0
    tick();                                  // cycle 1
    check("t2_first_addr", 64'(reg_addr_out), 64'h000010);
    tick();
    tick();                                  // cycle 3
    check("t2_m0_ack", 64'(m_ack), 64'h1);
    check("t2_m0_rdata", 64'(m_rd_data), 64'haaaa_0000);
    m_req      = 2'b10;
    slave_data = 32'hbbbb_1111;
    tick();                                  // cycle 4
    check("t2_gap_c4", 64'(reg_req_out), 64'h0);
    tick();                                  // cycle 5
    check("t2_gap_c5", 64'(reg_req_out), 64'h0);
    tick();                                  // cycle 6
    check("t2_m1_req_c6", 64'(reg_req_out), 64'h1);
    check("t2_m1_addr", 64'(reg_addr_out), 64'h100020);
    tick();
    tick();                                  // cycle 8
    check("t2_m1_ack", 64'(m_ack), 64'h2);
    check("t2_m1_rdata", 64'(m_rd_data), 64'hbbbb_1111);
    m_req = 2'b00;
    tick();
    tick();

    // ---- 3: write from m0 while m1 pending; bus fields latched ----
    set_master(0, 1'b0, 23'h2000a4, 32'hcafe_0001);
    set_master(1, 1'b1, 23'h300008, 32'h0);
    slave_data = 32'h5555_6666;
    m_req      = 2'b11;
    tick();                                  // cycle 1
    check("t3_rw", 64'(reg_rd_wr_L_out), 64'h0);
    check("t3_wd", 64'(reg_wr_data_out), 64'hcafe_0001);
    check("t3_addr", 64'(reg_addr_out), 64'h2000a4);
    set_master(0, 1'b0, 23'h2000a4, 32'h0);  // bus must keep the latched value
    tick();                                  // cycle 2
    check("t3_wd_hold", 64'(reg_wr_data_out), 64'hcafe_0001);
    wait_ack("t3_m0_ack", 2'b01, 10);
    m_req      = 2'b10;
    slave_data = 32'h7777_8888;
    wait_ack("t3_m1_ack", 2'b10, 12);
    check("t3_m1_rdata", 64'(m_rd_data), 64'h7777_8888);
    check("t3_m1_addr", 64'(reg_addr_out), 64'h300008);
    m_req = 2'b00;
    tick();
    tick();

    // ---- Round-robin: the master that just completed loses the next tie ----
    set_master(0, 1'b1, 23'h000044, 32'h0);
    m_req = 2'b01;
    wait_ack("rr_m0_solo", 2'b01, 10);
    m_req = 2'b00;
    tick();
    tick();
    tick();
    m_req = 2'b11;
    wait_ack("rr_m1_first", 2'b10, 10);
    m_req = 2'b01;
    wait_ack("rr_m0_second", 2'b01, 12);
    m_req = 2'b00;
    tick();
    tick();
    tick();

    // ---- 4: slave holds ack 3 extra cycles; DRAIN blocks the next grant ----
    slave_hold = 3;
    set_master(1, 1'b1, 23'h3000f0, 32'h0);
    m_req = 2'b01;                           // cycle 0; rr_ptr is 1, only m0 asks
    wait_ack("t4_m0_ack", 2'b01, 10);        // cycle 3
    m_req      = 2'b10;
    slave_hold = 0;
    for (int c = 4; c <= 8; c++) begin
      tick();
      check($sformatf("t4_drain_req_c%0d", c), 64'(reg_req_out), 64'h0);
      check($sformatf("t4_drain_ack_c%0d", c), 64'(m_ack), 64'h0);
    end
    tick();                                  // cycle 9
    check("t4_regrant_req", 64'(reg_req_out), 64'h1);
    check("t4_regrant_addr", 64'(reg_addr_out), 64'h3000f0);
    wait_ack("t4_m1_ack", 2'b10, 10);
    m_req = 2'b00;
    tick();
    tick();
    tick();

    // ---- 5: slave never acks ----
    slave_en   = 1'b0;
    slave_data = 32'h0;
    m_req      = 2'b01;                      // cycle 0; rr_ptr is 0
`ifdef GENEVR_REG_ARB_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) tick();    // cycle 16: last REQ cycle
    check("t5_no_early_ack", 64'(m_ack), 64'h0);
    check("t5_req_held", 64'(reg_req_out), 64'h1);
    tick();                                  // cycle 17
    check("t5_to_ack", 64'(m_ack), 64'h1);
    check("t5_to_rdata", 64'(m_rd_data), 64'hdead_beef);
    check("t5_to_err", 64'(m_err), 64'h1);
    check("t5_to_req_drop", 64'(reg_req_out), 64'h0);
    m_req = 2'b10;                           // new grant goes to m1, then stalls
`else
    begin
      int acks_before;
      acks_before = ack_total;
      for (int c = 1; c <= 40; c++) tick();
      check("t5_never_ack", 64'(ack_total), 64'(acks_before));
      check("t5_err_tied", 64'(m_err), 64'h0);
      check("t5_req_held", 64'(reg_req_out), 64'h1);
    end
    m_req = 2'b10;
`endif
    tick();
    tick();
    tick();

    // ---- 6: reset in REQ, then a fresh transaction ----
    check("t6_in_req", 64'(reg_req_out), 64'h1);
    reset = 1'b1;
    m_req = 2'b00;
    tick();
    check("t6_rst_req", 64'(reg_req_out), 64'h0);
    check("t6_rst_ack", 64'(m_ack), 64'h0);
    check("t6_rst_err", 64'(m_err), 64'h0);
    reset    = 1'b0;
    slave_en = 1'b1;
    begin
      int acks_before;
      acks_before = ack_total;
      tick();
      tick();
      tick();
      check("t6_no_ack_after_rst", 64'(ack_total), 64'(acks_before));
    end
    set_master(0, 1'b1, 23'h0abcde, 32'h0);
    set_master(1, 1'b1, 23'h1abcde, 32'h0);
    slave_data = 32'h0bad_f00d;
    m_req      = 2'b11;                      // cycle 0; rr_ptr back to 0
    tick();                                  // cycle 1
    check("t6_fresh_req", 64'(reg_req_out), 64'h1);
    check("t6_fresh_addr", 64'(reg_addr_out), 64'h0abcde);
    tick();
    tick();                                  // cycle 3
    check("t6_fresh_ack", 64'(m_ack), 64'h1);
    check("t6_fresh_rdata", 64'(m_rd_data), 64'h0bad_f00d);
    check("t6_fresh_err", 64'(m_err), 64'h0);
    m_req      = 2'b10;
    slave_data = 32'h1111_2222;
    wait_ack("t6_m1_ack", 2'b10, 12);
    check("t6_m1_rdata", 64'(m_rd_data), 64'h1111_2222);
    m_req = 2'b00;
    tick();
    tick();

    // ---- Whole-run protocol properties ----
    check("mon_ack_onehot", 64'(multi_hot), 64'h0);
    check("mon_bus_stable", 64'(unstable), 64'h0);
    check("mon_err_with_ack", 64'(err_no_ack), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
